// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - MIPS program counter, next-PC select and RUN/HALT/FAULT fetch control
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ADDR_W    = 6,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [31:0]       instr,
    input  logic              branch_taken,
    input  logic [15:0]       branch_off,
    input  logic              jump,
    input  logic [25:0]       jump_idx,
    input  logic              jr,
    input  logic [31:0]       jr_target,
    output logic [31:0]       pc,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       pc_plus4,
    output logic              halted,
    output logic              fault,
    output logic [31:0]       retired
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        is_halt;
    logic        jr_misaligned;
    logic        advance;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] next_pc;

    assign pc_plus4      = pc + 32'd4;
    assign addr          = pc[ADDR_W+1:2];
    assign is_halt       = (instr == HALT_WORD);
    assign jr_misaligned = jr && (jr_target[1:0] != 2'b00);

    // Branch offset is a signed word count; shift into bytes before adding.
    assign branch_target = pc_plus4 + {{14{branch_off[15]}}, branch_off, 2'b00};
    assign jump_target   = {pc_plus4[31:28], jump_idx, 2'b00};

    // Only a clean RUN cycle moves pc; halt and fault both freeze it in place.
    assign advance = (state == RUN) && !stall && !is_halt && !jr_misaligned;

    always_comb begin
        next_pc = pc_plus4;
        if (jr) begin
            next_pc = jr_target;
        end else if (jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            RUN: begin
                if (!stall) begin
                    if (is_halt) begin
                        next_state = HALT;
                    end else if (jr_misaligned) begin
                        next_state = FAULT;
                    end
                end
            end
            HALT:    next_state = HALT;
            FAULT:   next_state = FAULT;
            default: next_state = FAULT;
        endcase
    end

    always_comb begin
        halted = 1'b0;
        fault  = 1'b0;
        case (state)
            HALT:    halted = 1'b1;
            FAULT:   fault  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            retired <= 32'd0;
        end else if (advance) begin
            pc <= next_pc;
            if (retired != 32'hFFFF_FFFF) begin
                retired <= retired + 32'd1;
            end
        end
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter and next-PC stage directly upstream of the single-cycle MIPS instruction memory. It holds the architectural PC and drives the word address into the instruction ROM. It receives the fetched instruction back combinationally in the same cycle. It selects the next PC from sequential, branch, jump and jump-register sources, and runs a RUN/HALT/FAULT control FSM with a retired-instruction counter.

Parameters:
RESET_PC, 32'h0000_0000, byte PC loaded on reset; must be word aligned.
ADDR_W, 6, instruction-memory word-address width (64 words).
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
stall  input  1  hold PC this cycle (datapath hazard/wait)
instr  input  32  instruction word returned by instruction memory for current addr
branch_taken  input  1  conditional branch resolved taken this cycle
branch_off  input  16  branch immediate (word offset, signed)
jump  input  1  J/JAL this cycle
jump_idx  input  26  J-format target index
jr  input  1  jump-register this cycle
jr_target  input  32  register value for JR
pc  output  32  current byte PC (registered)
addr  output  ADDR_W  word address to instruction memory = pc[ADDR_W+1:2]
pc_plus4  output  32  pc + 4 (combinational, for JAL link)
halted  output  1  FSM in HALT
fault  output  1  FSM in FAULT
retired  output  32  count of instructions retired

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. On rst assertion, immediately: pc=RESET_PC, state=RUN, retired=0, halted=0, fault=0. Reset mid-operation, including from HALT or FAULT, restarts from RESET_PC.
- Outputs: addr and pc are registered and change only on a clock edge or reset. pc_plus4 is pc+4, wrapping mod 2^32.
- Memory interface: instr is valid in the same cycle as addr, because the memory read is asynchronous.
- FSM states: RUN, HALT, FAULT.
  - RUN -> HALT: when instr==HALT_WORD and stall=0. pc holds at the halt instruction's address. The halt word is not counted as retired.
  - RUN -> FAULT: when stall=0, no halt, jr=1, and jr_target[1:0]!=0. pc holds and retired is not incremented.
  - HALT and FAULT are absorbing. Only rst exits them. In these states all control inputs are ignored and pc and retired hold.
- Next PC in RUN with stall=0 and no halt/fault. Priority is jr > jump > branch_taken > sequential:
  - jr: jr_target.
  - jump: {pc_plus4[31:28], jump_idx, 2'b00}.
  - branch_taken: pc_plus4 + (sign_extend(branch_off) << 2), 32-bit wrap.
  - otherwise: pc_plus4.
- Retired counter: increments by 1 on every RUN cycle that advances pc. It saturates at 32'hFFFF_FFFF.
- Stall: stall=1 holds pc and retired and suppresses halt/fault detection for that cycle. Simultaneous redirect inputs during stall are discarded, so the datapath must re-present them.
- Address wrap: pc beyond 4*2^ADDR_W-1 aliases into memory via addr truncation. No error is raised; pc itself is kept full 32-bit.
- Concurrent redirects: simultaneous jump and branch_taken obey priority with no error. A misaligned jr_target is checked only when jr wins selection.

Test Plan:
- Reset/sequential: assert rst for 2 cycles, release, 5 cycles of NOP (32'h0) -> pc 0,4,8,12,16,20; addr 0..5; retired=5. Assert rst async between edges -> pc=0 and retired=0 before the next edge.
- Branch: at pc=0x10, branch_taken=1 and branch_off=16'hFFFC -> next pc=0x04. At pc=0x04, branch_off=16'h0003 -> next pc=0x14.
- Priority/jump: at pc=0x20, assert jr=1 with jr_target=0x40, jump=1 with jump_idx=0x10, and branch_taken=1 together -> pc=0x40. Next cycle assert jump only with jump_idx=0x10 -> pc=0x40 (target = idx<<2).
- Stall: hold stall=1 for 3 cycles with branch_taken=1 -> pc and retired unchanged. Release stall with no redirect -> pc advances by 4.
- Halt: place HALT_WORD at word 3 and run from reset -> pc stops at 0x0C, halted=1, retired=3. Further jump and branch inputs have no effect. rst -> pc=0, halted=0.
- Fault: jr=1 with jr_target=0x22 -> fault=1, pc holds, retired unchanged. Repeat with stall=1 asserted in the same cycle -> no fault, and pc holds.
